rll_key_loader: RTL and testbench

Loads the 32-bit unlock key for a random-logic-locked (RLL) netlist from a byte-wide framed stream and holds it in an atomically updated register. The register drives the netlist's keyIn_0_0..keyIn_0_31 inputs, with key_out[i] feeding keyIn_0_i. The block sits between the key-delivery link (test controller or secure-storage reader) and the locked combinational core. It is the supply side of the key interface that the locked core consumes.

---
 rtl/rll_key_loader.sv | 173 +++++++++++++++++
 tb/tb_rll_key_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rll_key_loader.sv
// rll_key_loader
// Loads the unlock key of a random-logic-locked netlist from a byte-wide framed
// stream. The committed key register updates only as a whole, either on a
// successful commit or on a clear, so the locked core never sees a partial key.
//
// Frame: HDR_BYTE, NBYTES key bytes (LSB first), checksum (XOR of key bytes).
// s_last must be set on the checksum byte only.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   s_valid, s_ready   stream handshake; byte accepted when both are high
//   s_data, s_last     stream byte and end-of-frame marker
//   key_lock           level; while high, commits and clears are refused
//   key_clear          single-cycle request to zero the committed key
//   key_out            committed key; bit i drives keyIn_0_i
//   key_valid          key_out holds a successfully committed key
//   load_done          one-cycle pulse on successful commit
//   load_err           one-cycle pulse on rejected frame
//   err_code           1 length, 2 checksum, 3 locked; held between errors
module rll_key_loader #(
  parameter int unsigned KEY_WIDTH = 32,
  parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  input  logic                 key_lock,
  input  logic                 key_clear,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 load_done,
  output logic                 load_err,
  output logic [1:0]           err_code
);

  localparam int unsigned NBYTES = KEY_WIDTH / 8;
  localparam int unsigned CntW   = $clog2(NBYTES + 1);
  localparam logic [CntW-1:0] NBytesC = CntW'(NBYTES);

  localparam logic [1:0] ErrLength = 2'd1;
  localparam logic [1:0] ErrCsum   = 2'd2;
  localparam logic [1:0] ErrLocked = 2'd3;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StCheck} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [7:0]             acc_q, acc_d;
  logic [7:0]             csum_q, csum_d;
  logic [KEY_WIDTH-1:0]   shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic                   load_done_q, load_done_d;
  logic                   load_err_q, load_err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   accept;

  // The only non-ready state is the one-cycle CHECK bubble.
  assign s_ready = (state_q != StCheck);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    csum_d      = csum_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    err_code_d  = err_code_q;

    // Clear first so that a commit in CHECK below overrides it.
    if (key_clear && !key_lock) begin
      key_d       = '0;
      key_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept && (s_data == HDR_BYTE) && !s_last) begin
          state_d = StLoad;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      StLoad: begin
        if (accept) begin
          if (cnt_q < NBytesC) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
              if (cnt_q == CntW'(i)) shadow_d[8*i +: 8] = s_data;
            end
            acc_d = acc_q ^ s_data;
            cnt_d = cnt_q + 1'b1;
            if (s_last) begin
              load_err_d = 1'b1;
              err_code_d = ErrLength;
              state_d    = StIdle;
            end
          end else begin
            csum_d = s_data;
            if (s_last) begin
              state_d = StCheck;
            end else begin
              load_err_d = 1'b1;
              err_code_d = ErrLength;
              state_d    = StDrain;
            end
          end
        end
      end

      StDrain: begin
        if (accept && s_last) state_d = StIdle;
      end

      StCheck: begin
        state_d = StIdle;
        if (csum_q != acc_q) begin
          load_err_d = 1'b1;
          err_code_d = ErrCsum;
        end else if (key_lock) begin
          load_err_d = 1'b1;
          err_code_d = ErrLocked;
        end else begin
          key_d       = shadow_q;
          key_valid_d = 1'b1;
          load_done_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      csum_q      <= '0;
      shadow_q    <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      csum_q      <= csum_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign key_out   = key_q;
  assign key_valid = key_valid_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Bench for rll_key_loader: directed frames from the test plan followed by
// random frames. The expected key/flags come from a frame-level model that
// knows only what each kind of frame must do to the committed key.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        key_lock;
  logic        key_clear;
  logic [31:0] key_out;
  logic        key_valid;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_err    = 0;

  // Frame-level model of the externally visible state.
  logic [31:0] exp_key;
  logic        exp_valid;
  logic [1:0]  exp_code;

  rll_key_loader #(.KEY_WIDTH(32), .HDR_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .key_lock  (key_lock),
    .key_clear (key_clear),
    .key_out   (key_out),
    .key_valid (key_valid),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".key_out"},   key_out,   exp_key);
    chk({tag, ".key_valid"}, {31'd0, key_valid}, {31'd0, exp_valid});
    chk({tag, ".err_code"},  {30'd0, err_code},  {30'd0, exp_code});
  endtask

  // Drives one byte (optionally after idle gaps), returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic last);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    chk("s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
  endfunction

  // Complete frame; xor_err != 0 corrupts the checksum. clr raises key_clear in CHECK.
  task automatic run_full(input logic [31:0] key, input logic [7:0] xor_err,
                          input logic lock, input logic clr);
    logic ok;
    key_lock = lock;
    ok = (xor_err == 8'h00);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(key[8*i +: 8], 1'b0);
    send_byte(csum_of(key) ^ xor_err, 1'b1);
    @(negedge clk);
    chk("check.s_ready", {31'd0, s_ready}, 32'd0);
    chk("check.load_done", {31'd0, load_done}, 32'd0);
    chk("check.key_out", key_out, exp_key);
    key_clear = clr;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    if (!ok) exp_code = 2'd2;
    else if (lock) exp_code = 2'd3;
    if (ok && !lock) begin
      exp_key   = key;
      exp_valid = 1'b1;
    end else if (clr && !lock) begin
      exp_key   = 32'd0;
      exp_valid = 1'b0;
    end
    @(negedge clk);
    chk("full.load_done", {31'd0, load_done}, {31'd0, ok && !lock});
    chk("full.load_err", {31'd0, load_err}, {31'd0, !(ok && !lock)});
    chk_state("full");
    @(negedge clk);
    chk("full.pulse_end", {30'd0, load_done, load_err}, 32'd0);
  endtask

  // Header plus k key bytes, s_last on the k-th.
  task automatic run_short(input logic [31:0] key, input int k);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < k; i++) send_byte(key[8*i +: 8], (i == k - 1));
    exp_code = 2'd1;
    @(negedge clk);
    chk("short.load_err", {31'd0, load_err}, 32'd1);
    chk("short.load_done", {31'd0, load_done}, 32'd0);
    chk_state("short");
    @(negedge clk);
    chk("short.pulse_end", {31'd0, load_err}, 32'd0);
  endtask

  // Full frame without s_last on the checksum, then n trailing bytes, last one marked.
  task automatic run_long(input logic [31:0] key, input logic [31:0] trail, input int n);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(key[8*i +: 8], 1'b0);
    send_byte(csum_of(key), 1'b0);
    exp_code = 2'd1;
    @(negedge clk);
    chk("long.load_err", {31'd0, load_err}, 32'd1);
    chk_state("long");
    for (int j = 0; j < n; j++) begin
      send_byte(trail[8*j +: 8], (j == n - 1));
      @(negedge clk);
      chk("drain.no_pulse", {30'd0, load_done, load_err}, 32'd0);
      chk_state("drain");
    end
  endtask

  task automatic stray(input logic [7:0] d, input logic last);
    send_byte(d, last);
    @(negedge clk);
    chk("stray.no_pulse", {30'd0, load_done, load_err}, 32'd0);
    chk_state("stray");
  endtask

  task automatic do_clear(input logic lock);
    @(negedge clk);
    key_clear = 1'b1;
    key_lock  = lock;
    @(posedge clk);
    #1;
    key_clear = 1'b0;
    if (!lock) begin
      exp_key   = 32'd0;
      exp_valid = 1'b0;
    end
    @(negedge clk);
    chk_state("clear");
  endtask

  task automatic model_reset();
    exp_key   = 32'd0;
    exp_valid = 1'b0;
    exp_code  = 2'd0;
  endtask

  initial begin
    logic [31:0] rk;
    logic [7:0]  rd;
    logic        rl;
    int          kind;

    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    key_lock = 1'b0; key_clear = 1'b0;
    model_reset();
    #12;
    chk("rst.s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst.pulses", {30'd0, load_done, load_err}, 32'd0);
    chk_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Test-plan sequence.
    run_full(32'h44332211, 8'h00, 1'b0, 1'b0);
    run_full(32'h44332211, 8'h01, 1'b0, 1'b0);
    run_short(32'h44332211, 3);
    run_full(32'h55667788, 8'h00, 1'b0, 1'b0);
    run_long(32'h44332211, 32'h0000_9977, 2);
    run_full(32'h44332211, 8'h00, 1'b0, 1'b0);
    run_full(32'hDEADBEEF, 8'h00, 1'b1, 1'b0);
    do_clear(1'b1);
    do_clear(1'b0);
    stray(8'h5A, 1'b0);
    stray(8'hA5, 1'b1);
    run_full(32'h44332211, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.s_ready", {31'd0, s_ready}, 32'd1);
    chk("midrst.pulses", {30'd0, load_done, load_err}, 32'd0);
    chk_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_full(32'hCAFEF00D, 8'h00, 1'b0, 1'b0);

    // Random frames.
    for (int it = 0; it < 60; it++) begin
      rk   = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1: run_full(rk, 8'h00, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
        2: run_full(rk, 8'h01 << $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1);
        3: run_short(rk, $urandom_range(1, 4));
        4: run_long(rk, $urandom, $urandom_range(1, 4));
        5: begin
          rd = 8'($urandom);
          rl = ($urandom_range(0, 1) == 1);
          if (rd == 8'hA5) rl = 1'b1;
          stray(rd, rl);
        end
        default: do_clear($urandom_range(0, 1) == 1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
